// File: rtl/scsp_midi_out.sv
// rtl/scsp_midi_out.sv - SCSP MIDI-out transmitter: MOBUF FIFO feeding an 8N1 serialiser on MIDI_TXD.
// Optional `define SCSP_MIDI_OUT_IRQ_EN adds IRQ_OE, a one-CE pulse on the rising edge of OE.
module scsp_midi_out #(
  parameter int BIT_DIV    = 723,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic [7:0] MOBUF_DI,
  input  logic       MOBUF_WE,
  output logic       MIDI_TXD,
  output logic       OE,
  output logic       OF,
  output logic       BUSY,
  output logic       OVF
`ifdef SCSP_MIDI_OUT_IRQ_EN
  ,
  output logic       IRQ_OE
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 12;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          pop, push, drop, timer_done, fifo_empty, oe_n;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    txd_n      = MIDI_TXD;
    pop        = 1'b0;
    fifo_empty = (count == '0);
    timer_done = (timer == TIMER_LAST);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          txd_n   = 1'b0;
          timer_n = '0;
          state_n = START;
        end
      end
      START: begin
        if (timer_done) begin
          timer_n   = '0;
          bit_idx_n = '0;
          txd_n     = shift[0];
          state_n   = DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (timer_done) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            txd_n     = shift[1];
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STOP: begin
        if (timer_done) begin
          timer_n = '0;
          // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    push = MOBUF_WE && ((count < DEPTH_C) || pop);
    drop = MOBUF_WE && !push;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    oe_n = (state_n == IDLE) && (count_n == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      MIDI_TXD <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OE       <= 1'b1;
      OF       <= 1'b0;
      BUSY     <= 1'b0;
      OVF      <= 1'b0;
`ifdef SCSP_MIDI_OUT_IRQ_EN
      IRQ_OE   <= 1'b0;
`endif
    end else if (CE) begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      MIDI_TXD <= txd_n;
      count    <= count_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      OE       <= oe_n;
      OF       <= (count_n == DEPTH_C);
      BUSY     <= (state_n != IDLE);
      OVF      <= drop;
`ifdef SCSP_MIDI_OUT_IRQ_EN
      IRQ_OE   <= oe_n && !OE;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (CE && push) mem[wr_ptr] <= MOBUF_DI;
  end

endmodule

// File: tb/tb_scsp_midi_out.sv
// tb/tb_scsp_midi_out.sv - self-checking bench for scsp_midi_out (BIT_DIV=4, FIFO_DEPTH=4).
module tb_scsp_midi_out;
  localparam int BD = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       we = 1'b0;
  logic [7:0] di = 8'h00;
  logic       txd, oe, of_f, busy, ovf;
`ifdef SCSP_MIDI_OUT_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  scsp_midi_out #(.BIT_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .CE(ce),
    .MOBUF_DI(di),
    .MOBUF_WE(we),
    .MIDI_TXD(txd),
    .OE(oe),
    .OF(of_f),
    .BUSY(busy),
    .OVF(ovf)
`ifdef SCSP_MIDI_OUT_IRQ_EN
    ,
    .IRQ_OE(irq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial receiver: counts CE cycles, samples each bit in its middle.
  logic       ce_q = 1'b0;
  int         ce_cnt = 0;
  int         m_state = 0;
  int         mcnt = 0;
  int         frames = 0;
  logic [7:0] mbyte = 8'h00;

  always @(posedge clk) ce_q <= ce;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0;
    end else if (ce_q) begin
      ce_cnt++;
      if (m_state == 0) begin
        if (txd === 1'b0) begin
          m_state = 1;
          mcnt = 0;
          start_q.push_back(ce_cnt);
        end
      end else begin
        mcnt++;
        if (mcnt == BD / 2) begin
          check("rx_start_bit", txd, 1'b0);
        end else if (mcnt >= BD && mcnt < 9 * BD && (mcnt % BD) == BD / 2) begin
          mbyte[mcnt / BD - 1] = txd;
        end else if (mcnt == 9 * BD + BD / 2) begin
          check("rx_stop_bit", txd, 1'b1);
          frames++;
          m_state = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_unexpected: got byte %0h, expected none", mbyte);
          end else begin
            check("rx_byte", mbyte, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit expect_accept);
    di = b;
    we = 1'b1;
    step(1);
    we = 1'b0;
    if (expect_accept) exp_q.push_back(b);
  endtask

  task automatic wait_txd_low();
    int k = 0;
    while (txd !== 1'b0 && k < 20) begin
      step(1);
      k++;
    end
    check("start_seen", txd, 1'b0);
  endtask

  task automatic wait_oe(input int limit, input string name);
    int k = 0;
    while (oe !== 1'b1 && k < limit) begin
      step(1);
      k++;
    end
    check(name, oe, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       ovf;
    logic       of_f;
  } vec_t;

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int f0;
    int irq_n;
    logic [3:0] snap;

    vt[0] = '{8'h01, 1'b0, 1'b0};
    vt[1] = '{8'h02, 1'b0, 1'b0};
    vt[2] = '{8'h03, 1'b0, 1'b0};
    vt[3] = '{8'h04, 1'b0, 1'b0};
    vt[4] = '{8'h05, 1'b0, 1'b1};
    vt[5] = '{8'h06, 1'b1, 1'b1};

    step(3);
    check("rst_txd", txd, 1'b1);
    check("rst_oe", oe, 1'b1);
    check("rst_of", of_f, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    ce = 1'b1;

    bad = 0;
    repeat (2000) begin
      step(1);
      if (txd !== 1'b1 || oe !== 1'b1 || of_f !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_2000", bad, 0);

    // Single frame 0xA5: exact start latency and 40-CE frame length.
    wr(8'hA5, 1'b1);
    check("a5_oe_low", oe, 1'b0);
    check("a5_not_yet", txd, 1'b1);
    step(1);
    check("a5_start_latency", txd, 1'b0);
    check("a5_busy", busy, 1'b1);
    n = 0;
    while (oe !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("a5_frame_len", n, 40);
`ifdef SCSP_MIDI_OUT_IRQ_EN
    check("a5_irq_pulse", irq, 1'b1);
    step(1);
    check("a5_irq_clear", irq, 1'b0);
`endif
    step(3);

    // Back-to-back frames, no gap, OE low across both.
    start_q.delete();
    wr(8'h00, 1'b1);
    wr(8'hFF, 1'b1);
    wait_txd_low();
    n = 0;
    irq_n = 0;
    while (oe !== 1'b1 && n < 300) begin
      step(1);
      n++;
`ifdef SCSP_MIDI_OUT_IRQ_EN
      if (irq === 1'b1) irq_n++;
`endif
    end
    check("b2b_oe_len", n, 80);
`ifdef SCSP_MIDI_OUT_IRQ_EN
    step(1);
    check("b2b_irq_count", irq_n, 1);
`endif
    check("b2b_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], 40);
    step(3);

    // Burst into a depth-4 FIFO: sixth byte dropped.
    for (int i = 0; i < 6; i++) begin
      di = vt[i].d;
      we = 1'b1;
      step(1);
      check($sformatf("burst_ovf_%0d", i), ovf, vt[i].ovf);
      check($sformatf("burst_of_%0d", i), of_f, vt[i].of_f);
      if (!vt[i].ovf) exp_q.push_back(vt[i].d);
    end
    we = 1'b0;
    step(1);
    check("burst_ovf_clear", ovf, 1'b0);
    // Write into a full FIFO on the cycle the first stop bit pops the next byte.
    step(34);
    check("full_before_pop", of_f, 1'b1);
    wr(8'h07, 1'b1);
    check("full_pop_wr_ovf", ovf, 1'b0);
    check("full_pop_wr_of", of_f, 1'b1);
    wait_oe(400, "burst_drain");
    check("burst_queue_empty", exp_q.size(), 0);
    step(3);

    // CE=0 mid-frame: everything holds, writes ignored.
    wr(8'h5A, 1'b1);
    step(10);
    snap = {txd, oe, busy, of_f};
    ce = 1'b0;
    di = 8'hEE;
    we = 1'b1;
    bad = 0;
    repeat (10) begin
      step(1);
      if ({txd, oe, busy, of_f} !== snap) bad++;
    end
    we = 1'b0;
    ce = 1'b1;
    check("ce_hold", bad, 0);
    wait_oe(100, "ce_hold_drain");
    step(3);

    // Asynchronous reset during bit 3 with two bytes queued.
    wr(8'h30, 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wait_txd_low();
    step(17);
    check("pre_reset_txd", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_txd_now", txd, 1'b1);
    check("reset_oe", oe, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_of", of_f, 1'b0);
    step(2);
    rst_n = 1'b1;
    f0 = frames;
    bad = 0;
    repeat (200) begin
      step(1);
      if (txd !== 1'b1 || oe !== 1'b1) bad++;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_frames", frames, f0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
